// File: rtl/mem_wb_skid_pkg.sv
// ============================================================================
// Module : lc3b_types (package)
// Brief  : LC-3b opcodes, control word, MEM/WB bundle and write-back decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic [3:0] {
        op_br    = 4'b0000,
        op_add   = 4'b0001,
        op_ldb   = 4'b0010,
        op_stb   = 4'b0011,
        op_jsr   = 4'b0100,
        op_and   = 4'b0101,
        op_ldr   = 4'b0110,
        op_str   = 4'b0111,
        op_extra = 4'b1000,
        op_not   = 4'b1001,
        op_ldi   = 4'b1010,
        op_sti   = 4'b1011,
        op_jmp   = 4'b1100,
        op_shf   = 4'b1101,
        op_lea   = 4'b1110,
        op_trap  = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic        mem_read;
        logic        mem_write;
        logic        load_cc;
        logic [1:0]  alu_mux_sel;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_control_word ctrl;
        lc3b_reg          dest;
        lc3b_word         alu;
        lc3b_word         mem;
        lc3b_word         pc;
        lc3b_word         adj9;
        lc3b_word         adj11;
        lc3b_word         src1;
        logic             jsr;
        logic             regwrite;
    } lc3b_memwb_bundle;

    function automatic logic is_wb_opcode(input lc3b_opcode op);
        case (op)
            op_add, op_and, op_ldb, op_ldr, op_ldi,
            op_lea, op_not, op_shf, op_extra: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_skid_entry.sv
// ============================================================================
// Module : memwb_entry
// Brief  : One bundle register with a valid bit and a data load-enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memwb_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         valid_next,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= valid_next;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_skid.sv
// ============================================================================
// Module : mem_wb_skid
// Brief  : MEM->WB pipeline stage with valid/ready handshake and optional skid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_skid
    import lc3b_types::*;
#(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3,
    parameter int SKID     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  lc3b_control_word    in_ctrl,
    input  logic [REG_BITS-1:0] in_dest,
    input  logic [WIDTH-1:0]    in_alu,
    input  logic [WIDTH-1:0]    in_mem_rdata,
    input  logic [WIDTH-1:0]    in_mem_fwd,
    input  logic [WIDTH-1:0]    in_pc,
    input  logic [WIDTH-1:0]    in_adj9,
    input  logic [WIDTH-1:0]    in_adj11,
    input  logic [WIDTH-1:0]    in_src1,
    input  logic                in_jsr,
    output logic                out_valid,
    input  logic                out_ready,
    output lc3b_control_word    out_ctrl,
    output logic [REG_BITS-1:0] out_dest,
    output logic [WIDTH-1:0]    out_alu,
    output logic [WIDTH-1:0]    out_mem,
    output logic [WIDTH-1:0]    out_pc,
    output logic [WIDTH-1:0]    out_adj9,
    output logic [WIDTH-1:0]    out_adj11,
    output logic [WIDTH-1:0]    out_src1,
    output logic                out_jsr,
    output logic                out_regwrite,
    output logic                cache_access_b
);

    // Width-parametrised twin of lc3b_memwb_bundle.
    typedef struct packed {
        lc3b_control_word    ctrl;
        logic [REG_BITS-1:0] dest;
        logic [WIDTH-1:0]    alu;
        logic [WIDTH-1:0]    mem;
        logic [WIDTH-1:0]    pc;
        logic [WIDTH-1:0]    adj9;
        logic [WIDTH-1:0]    adj11;
        logic [WIDTH-1:0]    src1;
        logic                jsr;
        logic                regwrite;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    bundle_t w_in_bundle;
    bundle_t w_main_d;
    bundle_t w_main_q;
    bundle_t w_skid_q;
    logic    w_main_valid;
    logic    w_skid_valid;
    logic    w_accept;
    logic    w_xfer;
    logic    w_main_load;
    logic    w_main_valid_next;
    logic    r_cache_access;

    always_comb begin
        w_in_bundle          = '0;
        w_in_bundle.ctrl     = in_ctrl;
        w_in_bundle.dest     = in_dest;
        w_in_bundle.alu      = in_alu;
        w_in_bundle.mem      = in_ctrl.mem_read ? in_mem_rdata : in_mem_fwd;
        w_in_bundle.pc       = in_pc;
        w_in_bundle.adj9     = in_adj9;
        w_in_bundle.adj11    = in_adj11;
        w_in_bundle.src1     = in_src1;
        w_in_bundle.jsr      = in_jsr;
        w_in_bundle.regwrite = is_wb_opcode(in_ctrl.opcode);
    end

    assign w_accept = in_valid && in_ready && !flush;
    assign w_xfer   = w_main_valid && out_ready;

    // Main refills from skid when one is waiting, otherwise from the input.
    assign w_main_load       = (w_accept && !w_skid_valid && (!w_main_valid || w_xfer))
                             || (w_skid_valid && w_xfer);
    assign w_main_d          = w_skid_valid ? w_skid_q : w_in_bundle;
    assign w_main_valid_next = !flush && (w_main_load || (w_main_valid && !w_xfer));

    memwb_entry #(.W(BW)) u_main (
        .clk        (clk),
        .reset      (reset),
        .load       (w_main_load),
        .valid_next (w_main_valid_next),
        .d          (w_main_d),
        .valid      (w_main_valid),
        .q          (w_main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_load;
            logic w_skid_valid_next;
            logic r_in_ready;

            assign w_skid_load       = w_accept && w_main_valid && !w_xfer;
            assign w_skid_valid_next = !flush && (w_skid_valid ? !w_xfer : w_skid_load);

            memwb_entry #(.W(BW)) u_skid (
                .clk        (clk),
                .reset      (reset),
                .load       (w_skid_load),
                .valid_next (w_skid_valid_next),
                .d          (w_in_bundle),
                .valid      (w_skid_valid),
                .q          (w_skid_q)
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= !w_skid_valid_next;
                end
            end

            assign in_ready = r_in_ready;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_q     = '0;
            assign in_ready     = !reset && (!w_main_valid || out_ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_access <= 1'b0;
        end else begin
            r_cache_access <= w_accept;
        end
    end

    assign out_valid      = w_main_valid;
    assign out_ctrl       = w_main_q.ctrl;
    assign out_dest       = w_main_q.dest;
    assign out_alu        = w_main_q.alu;
    assign out_mem        = w_main_q.mem;
    assign out_pc         = w_main_q.pc;
    assign out_adj9       = w_main_q.adj9;
    assign out_adj11      = w_main_q.adj11;
    assign out_src1       = w_main_q.src1;
    assign out_jsr        = w_main_q.jsr;
    assign out_regwrite   = w_main_q.regwrite && w_main_valid;
    assign cache_access_b = r_cache_access;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
// ============================================================================
// Module : tb_mem_wb_skid
// Brief  : Self-checking bench for mem_wb_skid, SKID=1 and SKID=0 instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_skid;
    import lc3b_types::*;

    localparam int W  = 16;
    localparam int R  = 3;
    localparam int CW = $bits(lc3b_control_word);

    typedef struct packed {
        lc3b_control_word ctrl;
        logic [R-1:0]     dest;
        logic [W-1:0]     alu;
        logic [W-1:0]     mem;
        logic [W-1:0]     pc;
        logic [W-1:0]     adj9;
        logic [W-1:0]     adj11;
        logic [W-1:0]     src1;
        logic             jsr;
        logic             rw;
    } exp_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready, in_jsr;
    lc3b_control_word in_ctrl;
    logic [R-1:0] in_dest;
    logic [W-1:0] in_alu, in_mem_rdata, in_mem_fwd, in_pc, in_adj9, in_adj11, in_src1;

    logic s1_in_ready, s1_out_valid, s1_out_jsr, s1_out_regwrite, s1_cab;
    lc3b_control_word s1_out_ctrl;
    logic [R-1:0] s1_out_dest;
    logic [W-1:0] s1_out_alu, s1_out_mem, s1_out_pc, s1_out_adj9, s1_out_adj11, s1_out_src1;

    logic s0_in_ready, s0_out_valid, s0_out_jsr, s0_out_regwrite, s0_cab;
    lc3b_control_word s0_out_ctrl;
    logic [R-1:0] s0_out_dest;
    logic [W-1:0] s0_out_alu, s0_out_mem, s0_out_pc, s0_out_adj9, s0_out_adj11, s0_out_src1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_wb_skid #(.WIDTH(W), .REG_BITS(R), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest), .in_alu(in_alu), .in_mem_rdata(in_mem_rdata),
        .in_mem_fwd(in_mem_fwd), .in_pc(in_pc), .in_adj9(in_adj9), .in_adj11(in_adj11),
        .in_src1(in_src1), .in_jsr(in_jsr), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_ctrl(s1_out_ctrl), .out_dest(s1_out_dest), .out_alu(s1_out_alu), .out_mem(s1_out_mem),
        .out_pc(s1_out_pc), .out_adj9(s1_out_adj9), .out_adj11(s1_out_adj11), .out_src1(s1_out_src1),
        .out_jsr(s1_out_jsr), .out_regwrite(s1_out_regwrite), .cache_access_b(s1_cab)
    );

    mem_wb_skid #(.WIDTH(W), .REG_BITS(R), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest), .in_alu(in_alu), .in_mem_rdata(in_mem_rdata),
        .in_mem_fwd(in_mem_fwd), .in_pc(in_pc), .in_adj9(in_adj9), .in_adj11(in_adj11),
        .in_src1(in_src1), .in_jsr(in_jsr), .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_ctrl(s0_out_ctrl), .out_dest(s0_out_dest), .out_alu(s0_out_alu), .out_mem(s0_out_mem),
        .out_pc(s0_out_pc), .out_adj9(s0_out_adj9), .out_adj11(s0_out_adj11), .out_src1(s0_out_src1),
        .out_jsr(s0_out_jsr), .out_regwrite(s0_out_regwrite), .cache_access_b(s0_cab)
    );

    // Reference model: one FIFO of expected bundles per instance.
    exp_t q1[$];
    exp_t q0[$];
    bit   m_ir1  = 1'b0;
    bit   m_cab1 = 1'b0;
    bit   m_cab0 = 1'b0;

    function automatic exp_t cur_in();
        exp_t e;
        e.ctrl  = in_ctrl;
        e.dest  = in_dest;
        e.alu   = in_alu;
        e.mem   = in_ctrl.mem_read ? in_mem_rdata : in_mem_fwd;
        e.pc    = in_pc;
        e.adj9  = in_adj9;
        e.adj11 = in_adj11;
        e.src1  = in_src1;
        e.jsr   = in_jsr;
        e.rw    = in_ctrl.opcode inside {op_add, op_and, op_ldb, op_ldr, op_ldi,
                                         op_lea, op_not, op_shf, op_extra};
        return e;
    endfunction

    initial begin : model
        bit   a1, a0;
        exp_t cur;
        forever begin
            @(posedge clk);
            if (reset) begin
                q1.delete(); q0.delete();
                m_ir1 = 1'b0; m_cab1 = 1'b0; m_cab0 = 1'b0;
            end else begin
                a1  = in_valid && m_ir1 && !flush;
                a0  = in_valid && (q0.size() == 0 || out_ready) && !flush;
                cur = cur_in();
                if (flush) begin
                    q1.delete(); q0.delete();
                end else begin
                    if (q1.size() != 0 && out_ready) void'(q1.pop_front());
                    if (a1) q1.push_back(cur);
                    if (q0.size() != 0 && out_ready) void'(q0.pop_front());
                    if (a0) q0.push_back(cur);
                end
                m_cab1 = a1;
                m_cab0 = a0;
                m_ir1  = (q1.size() < 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input lc3b_opcode op, input logic mr, input logic [W-1:0] rdata,
                         input logic [W-1:0] fwd, input logic [W-1:0] alu, input logic [R-1:0] dest);
        in_ctrl          = '0;
        in_ctrl.opcode   = op;
        in_ctrl.mem_read = mr;
        in_mem_rdata     = rdata;
        in_mem_fwd       = fwd;
        in_alu           = alu;
        in_dest          = dest;
        in_pc            = 16'h3000;
        in_adj9          = 16'h0012;
        in_adj11         = 16'h0345;
        in_src1          = 16'h5A5A;
        in_jsr           = 1'b0;
        in_valid         = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_dest = '0; in_alu = '0; in_mem_rdata = '0; in_mem_fwd = '0;
        in_pc = '0; in_adj9 = '0; in_adj11 = '0; in_src1 = '0; in_jsr = 1'b0;
        tick(); tick();
        @(negedge clk);
        total++; if (s1_in_ready !== 1'b0) $display("FAIL rst_ready1_during got %b exp 0", s1_in_ready); else passed++;
        total++; if (s0_in_ready !== 1'b0) $display("FAIL rst_ready0_during got %b exp 0", s0_in_ready); else passed++;
        reset = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if ({s1_out_valid, s1_out_regwrite, s1_cab, s1_out_ctrl, s1_out_dest, s1_out_alu, s1_out_mem,
             s1_out_pc, s1_out_adj9, s1_out_adj11, s1_out_src1, s1_out_jsr} !== '0)
            $display("FAIL rst_outputs1 got nonzero outputs exp all 0 (valid %b mem %h)", s1_out_valid, s1_out_mem);
        else passed++;
        total++;
        if ({s0_out_valid, s0_out_regwrite, s0_cab, s0_out_alu, s0_out_mem} !== '0)
            $display("FAIL rst_outputs0 got nonzero outputs exp all 0 (valid %b mem %h)", s0_out_valid, s0_out_mem);
        else passed++;
        total++; if (s1_in_ready !== 1'b1) $display("FAIL rst_ready1_after got %b exp 1", s1_in_ready); else passed++;
        total++; if (s0_in_ready !== 1'b1) $display("FAIL rst_ready0_after got %b exp 1", s0_in_ready); else passed++;
    endtask

    task automatic test_ldr();
        out_ready = 1'b1;
        drive(op_ldr, 1'b1, 16'hBEEF, 16'h1234, 16'h0101, 3'd3);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b1) $display("FAIL ldr_valid got %b exp 1", s1_out_valid); else passed++;
        total++; if (s1_out_mem !== 16'hBEEF) $display("FAIL ldr_mem got %h exp beef", s1_out_mem); else passed++;
        total++; if (s1_out_dest !== 3'd3) $display("FAIL ldr_dest got %0d exp 3", s1_out_dest); else passed++;
        total++; if (s1_out_regwrite !== 1'b1) $display("FAIL ldr_regwrite got %b exp 1", s1_out_regwrite); else passed++;
        total++; if (s1_cab !== 1'b1) $display("FAIL ldr_cache_access got %b exp 1", s1_cab); else passed++;
        tick();
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b0) $display("FAIL ldr_drain got %b exp 0", s1_out_valid); else passed++;
        total++; if (s1_cab !== 1'b0) $display("FAIL ldr_cab_pulse got %b exp 0", s1_cab); else passed++;
    endtask

    task automatic test_str_br();
        out_ready = 1'b1;
        drive(op_str, 1'b0, 16'hAAAA, 16'h5678, 16'h0202, 3'd1);
        tick();
        drive(op_br, 1'b0, 16'h1111, 16'h2222, 16'h0303, 3'd2);
        @(negedge clk);
        total++; if (s1_out_mem !== 16'h5678) $display("FAIL str_mem got %h exp 5678", s1_out_mem); else passed++;
        total++; if (s1_out_regwrite !== 1'b0) $display("FAIL str_regwrite got %b exp 0", s1_out_regwrite); else passed++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b1 || s1_out_alu !== 16'h0303) $display("FAIL br_present got v%b alu %h exp v1 alu 0303", s1_out_valid, s1_out_alu); else passed++;
        total++; if (s1_out_regwrite !== 1'b0) $display("FAIL br_regwrite got %b exp 0", s1_out_regwrite); else passed++;
    endtask

    task automatic test_skid_stall();
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        drive(op_add, 1'b0, 16'h0, 16'h0A0A, 16'hAAAA, 3'd1);
        tick();
        drive(op_and, 1'b0, 16'h0, 16'h0B0B, 16'hBBBB, 3'd2);
        tick();
        drive(op_not, 1'b0, 16'h0, 16'h0C0C, 16'hCCCC, 3'd4);
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b1 || s1_out_alu !== 16'hAAAA) $display("FAIL stall_hold_a got v%b alu %h exp v1 aaaa", s1_out_valid, s1_out_alu); else passed++;
        total++; if (s1_in_ready !== 1'b0) $display("FAIL stall_full_ready got %b exp 0", s1_in_ready); else passed++;
        tick();
        @(negedge clk);
        total++; if (s1_out_alu !== 16'hAAAA) $display("FAIL stall_still_a got %h exp aaaa", s1_out_alu); else passed++;
        total++; if (s1_in_ready !== 1'b0) $display("FAIL stall_c_blocked got %b exp 0", s1_in_ready); else passed++;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b1 || s1_out_alu !== 16'hBBBB) $display("FAIL drain_b got v%b alu %h exp v1 bbbb", s1_out_valid, s1_out_alu); else passed++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b1 || s1_out_alu !== 16'hCCCC) $display("FAIL drain_c got v%b alu %h exp v1 cccc", s1_out_valid, s1_out_alu); else passed++;
        tick();
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", s1_out_valid); else passed++;
    endtask

    task automatic test_flush_full();
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        drive(op_ldr, 1'b1, 16'h1A1A, 16'h0, 16'h0001, 3'd1);
        tick();
        drive(op_ldb, 1'b1, 16'h2B2B, 16'h0, 16'h0002, 3'd2);
        tick();
        drive(op_lea, 1'b0, 16'h0, 16'h3C3C, 16'h0003, 3'd3);
        flush = 1'b1;
        @(negedge clk);
        total++; if (s1_in_ready !== 1'b0) $display("FAIL flush_pre_full got %b exp 0", s1_in_ready); else passed++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", s1_out_valid); else passed++;
        total++; if (s1_in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", s1_in_ready); else passed++;
        total++; if (s1_cab !== 1'b0) $display("FAIL flush_cab got %b exp 0", s1_cab); else passed++;
        total++; if (s0_out_valid !== 1'b0) $display("FAIL flush_valid0 got %b exp 0", s0_out_valid); else passed++;
        out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        total++; if (s1_out_valid !== 1'b0) $display("FAIL flush_no_ghost got %b exp 0", s1_out_valid); else passed++;
    endtask

    // Phase 1: continuous input with out_ready toggling; phase 2: fully random with flush.
    task automatic test_random();
        exp_t act;
        for (int c = 0; c < 500; c++) begin
            in_ctrl      = CW'($urandom);
            in_dest      = R'($urandom);
            in_alu       = W'($urandom);
            in_mem_rdata = W'($urandom);
            in_mem_fwd   = W'($urandom);
            in_pc        = W'($urandom);
            in_adj9      = W'($urandom);
            in_adj11     = W'($urandom);
            in_src1      = W'($urandom);
            in_jsr       = 1'($urandom);
            if (c < 150) begin
                in_valid = 1'b1; out_ready = c[0]; flush = 1'b0;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom_range(0, 1));
                flush     = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            total++; if (s1_out_valid !== (q1.size() != 0)) $display("FAIL rnd_valid1 cyc %0d got %b exp %b", c, s1_out_valid, q1.size() != 0); else passed++;
            total++; if (s1_in_ready !== m_ir1) $display("FAIL rnd_ready1 cyc %0d got %b exp %b", c, s1_in_ready, m_ir1); else passed++;
            total++; if (s1_cab !== m_cab1) $display("FAIL rnd_cab1 cyc %0d got %b exp %b", c, s1_cab, m_cab1); else passed++;
            act = {s1_out_ctrl, s1_out_dest, s1_out_alu, s1_out_mem, s1_out_pc, s1_out_adj9,
                   s1_out_adj11, s1_out_src1, s1_out_jsr, s1_out_regwrite};
            total++;
            if (q1.size() != 0) begin
                if (act !== q1[0]) $display("FAIL rnd_data1 cyc %0d got %h exp %h", c, act, q1[0]); else passed++;
            end else begin
                if (s1_out_regwrite !== 1'b0) $display("FAIL rnd_rw_idle1 cyc %0d got %b exp 0", c, s1_out_regwrite); else passed++;
            end
            total++; if (s0_out_valid !== (q0.size() != 0)) $display("FAIL rnd_valid0 cyc %0d got %b exp %b", c, s0_out_valid, q0.size() != 0); else passed++;
            total++; if (s0_in_ready !== (q0.size() == 0 || out_ready)) $display("FAIL rnd_ready0 cyc %0d got %b exp %b", c, s0_in_ready, q0.size() == 0 || out_ready); else passed++;
            total++; if (s0_cab !== m_cab0) $display("FAIL rnd_cab0 cyc %0d got %b exp %b", c, s0_cab, m_cab0); else passed++;
            act = {s0_out_ctrl, s0_out_dest, s0_out_alu, s0_out_mem, s0_out_pc, s0_out_adj9,
                   s0_out_adj11, s0_out_src1, s0_out_jsr, s0_out_regwrite};
            total++;
            if (q0.size() != 0) begin
                if (act !== q0[0]) $display("FAIL rnd_data0 cyc %0d got %h exp %h", c, act, q0[0]); else passed++;
            end else begin
                if (s0_out_regwrite !== 1'b0) $display("FAIL rnd_rw_idle0 cyc %0d got %b exp 0", c, s0_out_regwrite); else passed++;
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str_br();
        test_skid_stall();
        test_flush_full();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
